// File: rtl/pair_triple_pkg.sv
// Shared types and the 2-of-3 majority helper used by the pair/triple scan sequencer.
package pair_triple_pkg;

    localparam int GROUP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return ((a | b) & c) | (a & b);
    endfunction

endpackage

// File: rtl/majority3.sv
// Combinational pair/triple evaluator: high when at least two of the three voter bits are set.
module majority3
    import pair_triple_pkg::*;
(
    input  logic [GROUP_W-1:0] grp,
    output logic               maj
);

    assign maj = maj3(grp[0], grp[1], grp[2]);

endmodule

// File: rtl/pair_triple_scan_ctrl.sv
// Snapshots all voter groups on a trigger, evaluates one group per cycle through a single
// majority3, then holds the result vector and its popcount until the consumer acks.
module pair_triple_scan_ctrl
    import pair_triple_pkg::*;
#(
    parameter  int NUM_GROUPS = 4,
    parameter  int MAX_COUNT  = 10_000_000,
    localparam int CNT_W      = $clog2(NUM_GROUPS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          auto_en,
    input  logic [GROUP_W*NUM_GROUPS-1:0] groups,
    output logic                          busy,
    output logic                          valid,
    input  logic                          ack,
    output logic [NUM_GROUPS-1:0]         result,
    output logic [CNT_W-1:0]              majority_count,
    output logic                          overrun
);

    localparam int IDX_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int TICK_W = $clog2(MAX_COUNT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MAX_COUNT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_GROUPS - 1);

    state_t                        state_reg;
    logic [GROUP_W*NUM_GROUPS-1:0] snapshot_reg;
    logic [IDX_W-1:0]              idx_reg;
    logic [TICK_W-1:0]             tick_cnt_reg;
    logic [NUM_GROUPS-1:0]         result_reg;
    logic [CNT_W-1:0]              count_reg;
    logic                          overrun_reg;

    logic                          tick;
    logic                          trigger;
    logic                          maj_bit;
    logic [GROUP_W-1:0]            snap_grp [NUM_GROUPS];
    logic [GROUP_W-1:0]            sel_grp;

    assign tick    = (tick_cnt_reg == TICK_LAST);
    assign trigger = start | (auto_en & tick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_split
            assign snap_grp[gi] = snapshot_reg[GROUP_W*gi +: GROUP_W];
        end
    endgenerate

    always_comb begin
        sel_grp = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (idx_reg == IDX_W'(g)) begin
                sel_grp = snap_grp[g];
            end
        end
    end

    majority3 u_majority3 (
        .grp (sel_grp),
        .maj (maj_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            snapshot_reg <= '0;
            idx_reg      <= '0;
            result_reg   <= '0;
            count_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        snapshot_reg <= groups;
                        idx_reg      <= '0;
                        result_reg   <= '0;
                        count_reg    <= '0;
                        state_reg    <= EVAL;
                    end
                end
                EVAL: begin
                    // result was cleared on the trigger edge, so OR-ing in each bit is enough
                    result_reg <= result_reg | (NUM_GROUPS'(maj_bit) << idx_reg);
                    count_reg  <= count_reg + CNT_W'(maj_bit);
                    if (idx_reg == IDX_LAST) begin
                        idx_reg   <= '0;
                        state_reg <= HOLD;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Only an enabled tick is a missed scan; a tick landing on the releasing ack edge still sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_reg <= 1'b0;
        end else if (auto_en && tick && (state_reg != IDLE)) begin
            overrun_reg <= 1'b1;
        end else if ((state_reg == HOLD) && ack) begin
            overrun_reg <= 1'b0;
        end
    end

    assign busy           = (state_reg == EVAL);
    assign valid          = (state_reg == HOLD);
    assign result         = result_reg;
    assign majority_count = count_reg;
    assign overrun        = overrun_reg;

endmodule

// File: doc/pair_triple_scan_ctrl.md
Name: pair_triple_scan_ctrl

Overview:
- Sequencer that time-shares one pair/triple (2-of-3 majority) evaluator across NUM_GROUPS three-bit voter groups.
- On a start request or a periodic tick, it snapshots all groups and evaluates one group per cycle. It then presents a result vector and a majority count to a downstream consumer under a valid/ack handshake.
- Sits between the ui_in switch inputs and the display/output logic of the tile.

Parameters:
- NUM_GROUPS, 4, number of 3-bit voter groups scanned; 1..8.
- MAX_COUNT, 10_000_000, auto-scan tick period in clk cycles; >= NUM_GROUPS+2.
- CNT_W, $clog2(NUM_GROUPS+1), width of majority_count (derived localparam, not overridable).

Ports:
- clk  input  1  single design clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- auto_en  input  1  enables periodic scans on internal tick.
- groups  input  3*NUM_GROUPS  voter bits; group g = groups[3g+2:3g], bit0=a, bit1=b, bit2=c.
- busy  output  1  high in EVAL.
- valid  output  1  results available (HOLD state).
- ack  input  1  consumer accepts results.
- result  output  NUM_GROUPS  result[g] = majority of group g.
- majority_count  output  CNT_W  number of set bits in result.
- overrun  output  1  sticky: a tick arrived while not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy, valid, result, majority_count, overrun = 0.
  - Snapshot register, index and tick counter = 0.
  - Effective mid-scan; no partial results survive.
- Majority function per group: out = ((a|b)&c) | (a&b).
- Tick counter:
  - Free-runs 0..MAX_COUNT-1 and wraps.
  - tick = 1 for one cycle when the counter equals MAX_COUNT-1.
  - Counter runs regardless of auto_en.
- Trigger = start | (auto_en & tick).
- States:
  - IDLE:
    - On a clock edge with trigger=1: snapshot <= groups, idx <= 0, result <= 0, majority_count <= 0, state <= EVAL.
    - A later change of groups does not affect the scan.
  - EVAL:
    - busy=1. Each edge: result[idx] <= maj(snapshot group idx), majority_count += that bit, idx++.
    - On the edge with idx = NUM_GROUPS-1: state <= HOLD.
  - HOLD:
    - valid=1; result and majority_count stable.
    - On an edge with ack=1: state <= IDLE and valid drops next cycle.
    - ack is allowed in the first valid cycle.
- Latency:
  - valid is visible exactly NUM_GROUPS edges after the trigger-sampling edge.
  - Minimum start-to-start period is NUM_GROUPS+2 cycles (trigger, NUM_GROUPS evals, ack).
- Boundary conditions:
  - start or tick outside IDLE: ignored. A tick outside IDLE also sets overrun.
  - overrun clears only on the ack edge that leaves HOLD, or on reset. If a tick coincides with that ack edge, set wins.
  - ack outside HOLD: ignored.
  - start and tick in the same IDLE cycle: a single scan.
  - result and majority_count hold their last scan's values in IDLE until the next trigger edge clears them.
- Width rules:
  - majority_count is unsigned and never exceeds NUM_GROUPS.
  - idx width is $clog2(NUM_GROUPS), minimum 1.

Decomposition:
- Shared package pair_triple_pkg holds:
  - state enum (IDLE=2'd0, EVAL=2'd1, HOLD=2'd2);
  - GROUP_W=3 constant;
  - maj3 function.
- One sub-module, majority3: purely combinational 3-in/1-out evaluator, instantiated once and fed by the snapshot mux on idx.
- Tick divider lives inline; it is not a separate module.

Test Plan:
- Basic scan: rst pulse, then groups=12'b111_011_100_000, start=1 for one cycle -> busy for 4 cycles; valid after 4 edges; result=4'b1100, majority_count=2; after ack, valid=0 and state IDLE.
- Snapshot isolation: start with groups=12'hFFF, then drive groups=0 on the next cycle -> result=4'b1111, count=4.
- Handshake hold plus ignored triggers: withhold ack for 20 cycles while pulsing start -> valid and result stable throughout, no new scan, overrun=0. ack in the first valid cycle with MAX_COUNT=6 auto off -> a back-to-back start is accepted on the next cycle.
- Auto mode: MAX_COUNT=8, auto_en=1, ack tied high -> a scan every 8 cycles, overrun stays 0. Then hold ack=0 across a tick -> overrun=1 until the ack edge.
- Reset mid-scan: assert rst during the 2nd EVAL cycle -> all outputs 0 immediately (asynchronous). After release, start -> full correct scan.
- Exhaustive majority: sweep all 8 patterns on group 0 with NUM_GROUPS=1 -> result[0]=1 exactly for 011, 101, 110, 111.
